// File: rtl/pipe_pkg.sv
// Shared constants and types for MIPS pipeline stage registers.
// Per-boundary bundle widths, control-bit positions and stage occupancy states.
package pipe_pkg;

  localparam int unsigned ALUOP_W      = 2;
  localparam int unsigned OCC_W        = 2;

  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 1 + ALUOP_W;
  localparam int unsigned ID_EX_DATA_W  = 80;
  localparam int unsigned EX_MEM_CTRL_W = 2;
  localparam int unsigned EX_MEM_DATA_W = 69;
  localparam int unsigned MEM_WB_CTRL_W = 1;
  localparam int unsigned MEM_WB_DATA_W = 37;

  // Bit positions inside the ID/EX control bundle
  localparam int unsigned REGWRITE_BIT = 2;
  localparam int unsigned ALUOP_LSB    = 0;

  // Encoding is {main valid, skid valid}; 2'b01 is unreachable
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_e;

  typedef struct packed {
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  function automatic logic [OCC_W-1:0] occ_count(input logic m_v, input logic s_v);
    return OCC_W'(m_v) + OCC_W'(s_v);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One pipeline slot: valid flag plus control and data registers.
// Clear wins over load; clear drops only the valid flag, payload is kept.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned         CTRL_W     = ID_EX_CTRL_W,
  parameter int unsigned         DATA_W     = ID_EX_DATA_W,
  parameter logic [DATA_W-1:0]   RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= RESET_DATA;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Main entry drives the outputs; skid entry absorbs one beat when downstream stalls.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W     = ID_EX_CTRL_W,
  parameter int unsigned       DATA_W     = ID_EX_DATA_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_state_e state_q, state_d;

  logic              in_fire, out_fire;
  logic              m_load, m_clear, m_from_skid;
  logic              s_load, s_clear;
  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
  logic [DATA_W-1:0] m_data, s_data, m_d_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != ST_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry load/clear enables for the current handshake
  always_comb begin
    m_load      = 1'b0;
    m_clear     = 1'b0;
    m_from_skid = 1'b0;
    s_load      = 1'b0;
    s_clear     = 1'b0;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: m_load = in_fire;
        ST_ONE: begin
          if (in_fire && out_fire) m_load  = 1'b1;
          else if (in_fire)        s_load  = 1'b1;
          else if (out_fire)       m_clear = 1'b1;
        end
        ST_FULL: begin
          if (out_fire) begin
            m_load      = 1'b1;
            m_from_skid = 1'b1;
            s_clear     = 1'b1;
          end
        end
        default: begin
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end

  assign m_d_ctrl = m_from_skid ? s_ctrl : in_ctrl;
  assign m_d_data = m_from_skid ? s_data : in_data;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (m_load),
    .clear  (m_clear),
    .d_ctrl (m_d_ctrl),
    .d_data (m_d_data),
    .valid  (m_valid),
    .ctrl   (m_ctrl),
    .data   (m_data)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (s_load),
    .clear  (s_clear),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .valid  (s_valid),
    .ctrl   (s_ctrl),
    .data   (s_data)
  );

  // Bubble masking keeps write-enables low on empty slots
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : CTRL_W'(0);
  assign out_data  = m_data;
  assign occupancy = occ_count(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, async reset, streaming and
// random traffic checked against a queue model, on a 3/80 and a 1/32 instance.
module tb_pipe_stage_reg;

  logic        clk, rst, flush, iv, ordy;
  logic [2:0]  ictrl;
  logic [79:0] idata;

  logic        w_ir, w_ov;
  logic [2:0]  w_ctrl;
  logic [79:0] w_data;
  logic [1:0]  w_occ;

  logic        n_ir, n_ov;
  logic [0:0]  n_ctrl;
  logic [31:0] n_data;
  logic [1:0]  n_occ;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [79:0] data;
  } ent_t;

  ent_t        q[$];
  logic [79:0] m_data;

  typedef struct {
    logic        v, r, f;
    logic [2:0]  ctrl;
    logic [79:0] data;
    logic        e_ov;
    logic [2:0]  e_ctrl;
    logic [79:0] e_data;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;

  vec_t tbl[11];

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(80), .RESET_DATA(80'(0))) dut_w (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv), .in_ready(w_ir), .in_ctrl(ictrl), .in_data(idata),
    .out_valid(w_ov), .out_ready(ordy), .out_ctrl(w_ctrl), .out_data(w_data),
    .occupancy(w_occ)
  );

  pipe_stage_reg #(.CTRL_W(1), .DATA_W(32), .RESET_DATA(32'(0))) dut_n (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv), .in_ready(n_ir), .in_ctrl(ictrl[0:0]), .in_data(idata[31:0]),
    .out_valid(n_ov), .out_ready(ordy), .out_ctrl(n_ctrl), .out_data(n_data),
    .occupancy(n_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic r, input logic f,
                              input logic [2:0] c, input logic [79:0] d,
                              input logic eov, input logic [2:0] ec,
                              input logic [79:0] ed, input logic [1:0] eocc,
                              input logic eir);
    vec_t x;
    x.v = v; x.r = r; x.f = f; x.ctrl = c; x.data = d;
    x.e_ov = eov; x.e_ctrl = ec; x.e_data = ed; x.e_occ = eocc; x.e_ir = eir;
    return x;
  endfunction

  task automatic cmp(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] ec;
    logic       ev;
    ev = (q.size() > 0);
    ec = ev ? q[0].ctrl : 3'b000;
    cmp("w_out_valid", 96'(w_ov),   96'(ev));
    cmp("w_out_ctrl",  96'(w_ctrl), 96'(ec));
    cmp("w_out_data",  96'(w_data), 96'(m_data));
    cmp("w_occupancy", 96'(w_occ),  96'(q.size()));
    cmp("w_in_ready",  96'(w_ir),   96'(q.size() < 2));
    cmp("n_out_valid", 96'(n_ov),   96'(ev));
    cmp("n_out_ctrl",  96'(n_ctrl), 96'(ec[0]));
    cmp("n_out_data",  96'(n_data), 96'(m_data[31:0]));
    cmp("n_occupancy", 96'(n_occ),  96'(q.size()));
    cmp("n_in_ready",  96'(n_ir),   96'(q.size() < 2));
  endtask

  // Drive one cycle, advance the reference queue at the edge, check at negedge
  task automatic step(input logic v, input logic r, input logic f,
                      input logic [2:0] c, input logic [79:0] d);
    logic in_fire, out_fire;
    iv = v; ordy = r; flush = f; ictrl = c; idata = d;
    @(posedge clk);
    in_fire  = v && (q.size() < 2);
    out_fire = r && (q.size() > 0);
    if (f) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire)  q.push_back({c, d});
    end
    if (q.size() > 0) m_data = q[0].data;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; ictrl = '0; idata = '0;
    m_data = '0;

    tbl[0]  = mk(1, 0, 0, 3'd1, 80'hA1, 1, 3'd1, 80'hA1, 2'd1, 1);
    tbl[1]  = mk(1, 0, 0, 3'd2, 80'hB2, 1, 3'd1, 80'hA1, 2'd2, 0);
    tbl[2]  = mk(1, 0, 0, 3'd3, 80'hC3, 1, 3'd1, 80'hA1, 2'd2, 0);
    tbl[3]  = mk(1, 1, 0, 3'd3, 80'hC3, 1, 3'd2, 80'hB2, 2'd1, 1);
    tbl[4]  = mk(1, 1, 0, 3'd3, 80'hC3, 1, 3'd3, 80'hC3, 2'd1, 1);
    tbl[5]  = mk(0, 1, 0, 3'd0, 80'h0,  0, 3'd0, 80'hC3, 2'd0, 1);
    tbl[6]  = mk(0, 0, 0, 3'd7, 80'hEE, 0, 3'd0, 80'hC3, 2'd0, 1);
    tbl[7]  = mk(1, 0, 0, 3'd5, 80'hD1, 1, 3'd5, 80'hD1, 2'd1, 1);
    tbl[8]  = mk(1, 0, 0, 3'd6, 80'hE2, 1, 3'd5, 80'hD1, 2'd2, 0);
    tbl[9]  = mk(1, 1, 1, 3'd7, 80'hF3, 0, 3'd0, 80'hD1, 2'd0, 1);
    tbl[10] = mk(0, 1, 0, 3'd7, 80'h0,  0, 3'd0, 80'hD1, 2'd0, 1);

    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].ctrl, tbl[i].data);
      cmp($sformatf("tbl%0d_out_valid", i), 96'(w_ov),   96'(tbl[i].e_ov));
      cmp($sformatf("tbl%0d_out_ctrl", i),  96'(w_ctrl), 96'(tbl[i].e_ctrl));
      cmp($sformatf("tbl%0d_out_data", i),  96'(w_data), 96'(tbl[i].e_data));
      cmp($sformatf("tbl%0d_occupancy", i), 96'(w_occ),  96'(tbl[i].e_occ));
      cmp($sformatf("tbl%0d_in_ready", i),  96'(w_ir),   96'(tbl[i].e_ir));
    end

    // Streaming at full rate: one cycle latency, never more than one held
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'b101, 80'(i));
      cmp($sformatf("stream%0d_data", i), 96'(w_data), 96'(i));
      cmp($sformatf("stream%0d_occ_le1", i), 96'(w_occ <= 2'd1), 96'(1));
    end
    step(1'b0, 1'b1, 1'b0, 3'b000, 80'h0);

    // Asynchronous reset in the middle of the low phase with both entries full
    step(1'b1, 1'b0, 1'b0, 3'd6, 80'h1234);
    step(1'b1, 1'b0, 1'b0, 3'd7, 80'h5678);
    #2;
    iv = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    m_data = '0;
    check_all();
    cmp("async_rst_ctrl", 96'(w_ctrl), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 3'd4, 80'h77);
    cmp("first_after_rst", 96'(w_data), 96'(80'h77));

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
           3'($urandom), {16'($urandom), $urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
